// File: rtl/srp_bram_reader.sv
// rtl/srp_bram_reader.sv - sequential circular BRAM reader streaming words through a credit-controlled FIFO
module srp_bram_reader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2097,
    parameter int FIFO_D = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    localparam int PTR_W = $clog2(FIFO_D);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] issue_left;
    logic [ADDR_W-1:0] out_left;
    // A read issued last cycle has its data on bram_dout this cycle.
    logic              rd_pend;

    logic [DATA_W-1:0] fifo_mem [FIFO_D];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  occ;

    logic [1:0]        in_flight;
    logic              credit_ok;
    logic              issue;
    logic              push;
    logic              pop;
    logic              bad_base;

    // Credits are taken from registered occupancy plus outstanding reads, so a
    // slot is always reserved for every word still coming back from the BRAM.
    assign in_flight = {1'b0, rd_pend};
    assign credit_ok = (32'(occ) + 32'(in_flight)) < FIFO_D;
    assign issue     = (state == S_READ) && (issue_left != '0) && credit_ok;
    assign push      = rd_pend;

    assign bram_en   = issue;
    assign bram_we   = 1'b0;
    assign bram_addr = rd_addr;

    assign m_valid   = (occ != '0);
    assign pop       = m_valid && m_ready;
    assign m_data    = fifo_mem[rd_ptr];
    assign m_last    = m_valid && (out_left == ONE);

    assign busy      = (state != S_IDLE);
    assign bad_base  = 32'(base_addr) >= DEPTH;

    // Command sequencing: accept/reject in IDLE, issue reads, finish on the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rd_addr    <= '0;
            issue_left <= '0;
            out_left   <= '0;
            rd_pend    <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done    <= 1'b0;
            err     <= 1'b0;
            rd_pend <= issue;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (bad_base) begin
                            err <= 1'b1;
                        end else if (length == '0) begin
                            done <= 1'b1;
                        end else begin
                            state      <= S_READ;
                            rd_addr    <= base_addr;
                            issue_left <= length;
                            out_left   <= length;
                        end
                    end
                end
                S_READ: begin
                    if (issue) begin
                        issue_left <= issue_left - ONE;
                        rd_addr    <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + ONE;
                        if (issue_left == ONE) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                default: ;
            endcase
            if (pop) begin
                out_left <= out_left - ONE;
                if (m_last) begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
            end
        end
    end

    // Output FIFO: captures returning BRAM data and hands it to the stream in order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < FIFO_D; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= bram_dout;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + CNT_W'(1);
                2'b01:   occ <= occ - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_srp_bram_reader.sv
// tb/tb_srp_bram_reader.sv - randomized self-checking bench for srp_bram_reader
module tb_srp_bram_reader;

    localparam int DEPTH  = 2097;
    localparam int FIFO_D = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] base_addr;
    logic [11:0] length;
    logic        busy, done, err;
    logic        bram_en, bram_we;
    logic [11:0] bram_addr;
    logic [31:0] bram_dout;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;

    srp_bram_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_dout (bram_dout),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last)
    );

    always #5 clk = ~clk;

    // BRAM with one-cycle read latency.
    logic [31:0] ram [4096];
    always @(posedge clk) begin
        if (bram_en) bram_dout <= ram[bram_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Ready driver: held high in mode 0, random in mode 1.
    int ready_mode = 0;
    always @(posedge clk) begin
        #2;
        m_ready = (ready_mode == 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
    end

    // Behavioural model state.
    int      exp_data[$];
    int      exp_addr[$];
    int      beat_log[$];
    int      beat_cyc[$];
    int      addr_log[$];
    bit      model_busy = 0;
    bit      exp_done = 0;
    bit      exp_err = 0;
    bit      stall_prev = 0;
    logic [31:0] stall_data;
    logic    stall_last;
    int      outstanding = 0;
    int      done_cnt = 0;
    int      err_cnt = 0;
    int      done_cyc = 0;
    int      cyc = 0;

    // Compare process: checks every output every cycle against the model.
    always @(negedge clk) begin
        bit nd, ne, fin;
        cyc++;
        if (rst_n !== 1'b1) begin
            exp_data.delete();
            exp_addr.delete();
            model_busy  = 0;
            exp_done    = 0;
            exp_err     = 0;
            stall_prev  = 0;
            outstanding = 0;
        end else begin
            chk("done", done, exp_done);
            chk("err", err, exp_err);
            chk("busy", busy, model_busy);
            chk("bram_we", bram_we, 0);
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (err) err_cnt++;
            if (bram_en) begin
                addr_log.push_back(int'(bram_addr));
                if (exp_addr.size() == 0) chk("bram_en_unexpected", bram_en, 0);
                else chk("bram_addr", bram_addr, exp_addr.pop_front());
                outstanding++;
                chk("credit_bound", outstanding <= FIFO_D, 1);
            end
            if (stall_prev) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, stall_data);
                chk("stall_last", m_last, stall_last);
            end
            nd  = 0;
            ne  = 0;
            fin = 0;
            if (!m_valid) begin
                chk("last_without_valid", m_last, 0);
            end else if (exp_data.size() == 0) begin
                chk("valid_unexpected", m_valid, 0);
            end else if (m_ready) begin
                chk("m_data", m_data, exp_data[0]);
                chk("m_last", m_last, exp_data.size() == 1);
                beat_log.push_back(int'(m_data));
                beat_cyc.push_back(cyc);
                outstanding--;
                if (exp_data.size() == 1) begin nd = 1; fin = 1; end
                void'(exp_data.pop_front());
            end
            stall_prev = m_valid && !m_ready;
            stall_data = m_data;
            stall_last = m_last;
            if (!model_busy && start) begin
                if (int'(base_addr) >= DEPTH) ne = 1;
                else if (length == 0) nd = 1;
                else begin
                    model_busy = 1;
                    for (int i = 0; i < int'(length); i++) begin
                        int a;
                        a = (int'(base_addr) + i) % DEPTH;
                        exp_addr.push_back(a);
                        exp_data.push_back(int'(ram[a]));
                    end
                end
            end
            if (fin) model_busy = 0;
            exp_done = nd;
            exp_err  = ne;
        end
    end

    task automatic cmd(input int b, input int l);
        @(posedge clk); #2;
        start = 1'b1; base_addr = 12'(b); length = 12'(l);
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (model_busy && n < 2000) begin @(posedge clk); n++; end
        chk(name, n < 2000, 1);
        repeat (3) @(posedge clk);
    endtask

    task automatic clear_logs();
        beat_log.delete(); beat_cyc.delete(); addr_log.delete();
    endtask

    initial begin
        int d0, e0, n, b, l;
        int wrap_a[5] = '{2094, 2095, 2096, 0, 1};
        for (int a = 0; a < 4096; a++) ram[a] = 32'(a + 'h100);
        rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0;
        #23;
        chk("rst_busy", busy, 0);     chk("rst_done", done, 0);
        chk("rst_err", err, 0);       chk("rst_bram_en", bram_en, 0);
        chk("rst_bram_addr", bram_addr, 0); chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0); chk("rst_m_data", m_data, 0);
        @(posedge clk); #2; rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic: 4 words from address 10, latency and back-to-back beats.
        clear_logs();
        cmd(10, 4);
        @(negedge clk); chk("lat_cycle1", m_valid, 0);
        @(negedge clk); chk("lat_cycle2", m_valid, 0);
        @(negedge clk); chk("lat_cycle3", m_valid, 1);
        wait_idle("basic_timeout");
        chk("basic_count", beat_log.size(), 4);
        if (beat_log.size() == 4) begin
            chk("basic_b0", beat_log[0], 32'h10A);
            chk("basic_b1", beat_log[1], 32'h10B);
            chk("basic_b2", beat_log[2], 32'h10C);
            chk("basic_b3", beat_log[3], 32'h10D);
            for (int i = 1; i < 4; i++) chk("basic_consec", beat_cyc[i] - beat_cyc[0], i);
            chk("basic_done_lat", done_cyc - beat_cyc[3], 1);
        end

        // Circular wrap at the end of the buffer.
        clear_logs();
        cmd(2094, 5);
        wait_idle("wrap_timeout");
        chk("wrap_addr_count", addr_log.size(), 5);
        chk("wrap_beat_count", beat_log.size(), 5);
        if (addr_log.size() == 5 && beat_log.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                chk("wrap_addr", addr_log[i], wrap_a[i]);
                chk("wrap_data", beat_log[i], wrap_a[i] + 'h100);
            end
        end

        // Backpressure: 16 words with random ready, then random commands.
        ready_mode = 1;
        clear_logs();
        cmd(300, 16);
        wait_idle("bp_timeout");
        chk("bp_count", beat_log.size(), 16);
        if (beat_log.size() == 16) chk("bp_last_word", beat_log[15], 32'h100 + 315);
        for (int k = 0; k < 8; k++) begin
            b = $urandom_range(0, DEPTH - 1);
            l = $urandom_range(1, 40);
            clear_logs();
            cmd(b, l);
            wait_idle("rand_timeout");
            chk("rand_count", beat_log.size(), l);
        end
        ready_mode = 0;

        // Zero length: done pulse, no reads, no beats.
        clear_logs();
        d0 = done_cnt;
        cmd(5, 0);
        repeat (3) @(posedge clk);
        chk("zero_done", done_cnt - d0, 1);
        chk("zero_reads", addr_log.size(), 0);
        chk("zero_beats", beat_log.size(), 0);

        // Out-of-range base: err pulse, no reads.
        clear_logs();
        e0 = err_cnt;
        cmd(2097, 3);
        repeat (3) @(posedge clk);
        chk("bad_err", err_cnt - e0, 1);
        chk("bad_reads", addr_log.size(), 0);
        chk("bad_busy", busy, 0);

        // Start while busy is ignored.
        clear_logs();
        e0 = err_cnt; d0 = done_cnt;
        cmd(100, 12);
        repeat (2) @(posedge clk);
        cmd(3000, 0);
        cmd(7, 2);
        wait_idle("mid_timeout");
        chk("mid_beats", beat_log.size(), 12);
        chk("mid_err", err_cnt - e0, 0);
        chk("mid_done", done_cnt - d0, 1);

        // Asynchronous reset mid-transfer.
        clear_logs();
        cmd(50, 8);
        n = 0;
        while (beat_log.size() < 3 && n < 100) begin @(posedge clk); n++; end
        chk("rst_wait_timeout", n < 100, 1);
        #3;
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);       chk("arst_done", done, 0);
        chk("arst_bram_en", bram_en, 0); chk("arst_bram_addr", bram_addr, 0);
        chk("arst_m_valid", m_valid, 0); chk("arst_m_last", m_last, 0);
        chk("arst_m_data", m_data, 0);
        repeat (3) @(posedge clk);
        #2; rst_n = 1'b1;
        repeat (4) @(posedge clk);
        chk("arst_no_done", done_cnt - d0, 0);
        clear_logs();
        cmd(7, 3);
        wait_idle("post_rst_timeout");
        chk("post_rst_count", beat_log.size(), 3);
        if (beat_log.size() == 3) begin
            chk("post_rst_b0", beat_log[0], 32'h107);
            chk("post_rst_b2", beat_log[2], 32'h109);
        end
        chk("post_rst_done", done_cnt - d0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
